// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control sequencer.
// State, trap-cause and NOP constants used by the core and the bench.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL  = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_FETCH_TO = 2'd2,
        CAUSE_DATA_TO  = 2'd3
    } trap_cause_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // States that hold a req up and may time out
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Bus-wait watchdog shared by the fetch and data handshakes.
// TIMEOUT of zero disables expiry so a req may wait forever.
module seq_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK100MHZ,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK100MHZ) begin
        if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/cpu_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Owns the PC, handles req/ack memory waits, traps, debug halt, instret.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 'h0000_0010,
    parameter int TIMEOUT = 255,
    parameter int CNT_W = 32
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  instr,
    input  logic             dec_illegal,
    input  logic             dec_is_mem,
    input  logic             dec_rd_en,
    input  logic             exec_taken,
    input  logic [XLEN-1:0]  exec_target,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    input  logic             halt_req,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [XLEN-1:0]  mepc,
    output logic [CNT_W-1:0] instret
);

    seq_state_t  st;
    trap_cause_t cause_q;
    logic [XLEN-1:0] next_pc;
    logic wait_clear;
    logic wait_run;
    logic wait_expired;

    // Counter stays cleared outside the wait states, so it reads zero on entry
    assign wait_clear = reset || !is_wait_state(st);
    assign wait_run   = ((st == ST_FETCH) && !imem_ack) ||
                        ((st == ST_MEM) && !dmem_ack);

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .CLK100MHZ (CLK100MHZ),
        .clear     (wait_clear),
        .run       (wait_run),
        .expired   (wait_expired)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            st      <= ST_FETCH;
            pc      <= RESET_VECTOR;
            next_pc <= RESET_VECTOR;
            instr   <= XLEN'(NOP);
            cause_q <= CAUSE_ILLEGAL;
            mepc    <= '0;
            instret <= '0;
        end else begin
            unique case (st)
                ST_FETCH: begin
                    // Ack beats a coincident expiry
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        st    <= ST_DECODE;
                    end else if (wait_expired) begin
                        cause_q <= CAUSE_FETCH_TO;
                        st      <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        cause_q <= CAUSE_ILLEGAL;
                        st      <= ST_TRAP;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    next_pc <= exec_taken ? exec_target
                                          : pc + XLEN'(4);
                    if (exec_taken && (exec_target[1:0] != 2'b00)) begin
                        cause_q <= CAUSE_MISALIGN;
                        st      <= ST_TRAP;
                    end else if (dec_is_mem) begin
                        st <= ST_MEM;
                    end else begin
                        st <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        st <= ST_WB;
                    end else if (wait_expired) begin
                        cause_q <= CAUSE_DATA_TO;
                        st      <= ST_TRAP;
                    end
                end
                ST_WB: begin
                    pc      <= next_pc;
                    instret <= instret + CNT_W'(1);
                    st      <= halt_req ? ST_HALT : ST_FETCH;
                end
                ST_TRAP: begin
                    mepc <= pc;
                    pc   <= TRAP_VECTOR;
                    st   <= halt_req ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        st <= ST_FETCH;
                    end
                end
                default: begin
                    st <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register
    assign imem_req   = (st == ST_FETCH) && !reset;
    assign dmem_req   = (st == ST_MEM) && !reset;
    assign rf_we      = (st == ST_WB) && dec_rd_en;
    assign trap       = (st == ST_TRAP);
    assign halted     = (st == ST_HALT);
    assign trap_cause = cause_q;
    assign state      = st;

endmodule
